// File: rtl/rca_nibble_serial_if.sv
// rtl/rca_nibble_serial_if.sv - request/result bundle for the nibble-serial adder sequencer
interface rca_nibble_serial_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/rca_nibble_serial_ctrl.sv
// rtl/rca_nibble_serial_ctrl.sv - WIDTH-bit add time-multiplexed over one 4-bit ripple slice
module rca_nibble_serial_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    rca_nibble_serial_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int SW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [SW-1:0] LAST = SW'(NIB - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SW-1:0]    step_q, step_d;
    logic [4:0]       slice;

    // The only adder: one combinational 4-bit ripple slice, carry linked through carry_q.
    assign slice = {1'b0, a_sh_q[3:0]} + {1'b0, b_sh_q[3:0]} + {4'b0000, carry_q};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    carry_d = bus.cin;
                    step_d  = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = {slice[3:0], acc_q[WIDTH-1:4]};
                carry_d = slice[4];
                a_sh_d  = {4'b0000, a_sh_q[WIDTH-1:4]};
                b_sh_d  = {4'b0000, b_sh_q[WIDTH-1:4]};
                step_d  = step_q + SW'(1);
                if (step_q == LAST) begin
                    // Results are published only here so they stay stable across the next run.
                    sum_d   = acc_d;
                    cout_d  = slice[4];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    step_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_rca_nibble_serial_ctrl.sv
// tb/tb_rca_nibble_serial_ctrl.sv - scoreboard bench for rca_nibble_serial_ctrl at WIDTH 16 and 8
module tb_rca_nibble_serial_ctrl;
    localparam int NIB16 = 4;
    localparam int NIB8  = 2;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    logic [16:0] q16[$];
    logic [8:0]  q8[$];

    rca_nibble_serial_if #(.WIDTH(16)) bus16 ();
    rca_nibble_serial_if #(.WIDTH(8))  bus8 ();

    rca_nibble_serial_ctrl #(.WIDTH(16)) dut16 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus16));
    rca_nibble_serial_ctrl #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_n_i(rst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic c);
        return 17'(a) + 17'(b) + 17'(c);
    endfunction

    function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
        return 9'(a) + 9'(b) + 9'(c);
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus16.done) begin
            if (q16.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL done16_unexpected: got DONE with empty scoreboard at %0t", $time);
            end else begin
                logic [16:0] e;
                e = q16.pop_front();
                chk("sb_sum16", 32'(bus16.sum), 32'(e[15:0]));
                chk("sb_cout16", 32'(bus16.cout), 32'(e[16]));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus8.done) begin
            if (q8.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL done8_unexpected: got DONE with empty scoreboard at %0t", $time);
            end else begin
                logic [8:0] e;
                e = q8.pop_front();
                chk("sb_sum8", 32'(bus8.sum), 32'(e[7:0]));
                chk("sb_cout8", 32'(bus8.cout), 32'(e[8]));
            end
        end
    end

    // Issue one op from idle and count cycles to DONE and cycles with BUSY high.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic c,
                         output int lat, output int nb);
        bus16.start = 1'b1;
        bus16.a     = a;
        bus16.b     = b;
        bus16.cin   = c;
        tick();
        q16.push_back(ref16(a, b, c));
        bus16.start = 1'b0;
        lat = 0;
        nb  = 0;
        while (!bus16.done && lat < 20) begin
            if (bus16.busy) nb++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, nb, gap, ops, it, cnt;
        logic st, acc, ed;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
        bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0;
        repeat (3) tick();
        chk("rst_busy16", 32'(bus16.busy), 0);
        chk("rst_done16", 32'(bus16.done), 0);
        chk("rst_sum16", 32'(bus16.sum), 0);
        chk("rst_cout16", 32'(bus16.cout), 0);
        chk("rst_busy8", 32'(bus8.busy), 0);
        rst_n = 1'b1;
        tick();

        run16(16'h1234, 16'h4321, 1'b1, lat, nb);
        chk("lat_1234", 32'(lat), 4);
        chk("busy_cycles_1234", 32'(nb), 4);
        chk("sum_1234", 32'(bus16.sum), 32'h5556);
        chk("cout_1234", 32'(bus16.cout), 0);
        chk("busy_at_done", 32'(bus16.busy), 0);

        run16(16'hFFFF, 16'h0001, 1'b0, lat, nb);
        chk("sum_ffff_1", 32'(bus16.sum), 32'h0000);
        chk("cout_ffff_1", 32'(bus16.cout), 1);
        run16(16'hFFFF, 16'hFFFF, 1'b1, lat, nb);
        chk("sum_ffff_ffff", 32'(bus16.sum), 32'hFFFF);
        chk("cout_ffff_ffff", 32'(bus16.cout), 1);
        tick();

        // START pulse mid-run must be ignored; SUM holds the previous result.
        bus16.start = 1'b1; bus16.a = 16'h1111; bus16.b = 16'h2222; bus16.cin = 1'b0;
        tick();
        q16.push_back(ref16(16'h1111, 16'h2222, 1'b0));
        bus16.start = 1'b0;
        tick();
        bus16.start = 1'b1; bus16.a = 16'h00F0; bus16.b = 16'h0010;
        chk("hold_sum_run", 32'(bus16.sum), 32'hFFFF);
        tick();
        bus16.start = 1'b0;
        chk("hold_sum_run2", 32'(bus16.sum), 32'hFFFF);
        chk("busy_during_ignored", 32'(bus16.busy), 1);
        lat = 0;
        while (!bus16.done && lat < 20) begin tick(); lat++; end
        chk("sum_ignored_start", 32'(bus16.sum), 32'h3333);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_extra_done", 32'(bus16.done), 0);
        end

        // Reset abort at step 2.
        bus16.start = 1'b1; bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.cin = 1'b0;
        tick();
        bus16.start = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus16.busy), 0);
        chk("abort_done", 32'(bus16.done), 0);
        chk("abort_sum", 32'(bus16.sum), 0);
        chk("abort_cout", 32'(bus16.cout), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("abort_no_done", 32'(bus16.done), 0);
        end

        // Back-to-back with START held; new operands presented in each DONE cycle.
        bus16.start = 1'b1; bus16.a = 16'h0005; bus16.b = 16'h000A; bus16.cin = 1'b1;
        tick();
        q16.push_back(ref16(16'h0005, 16'h000A, 1'b1));
        lat = 0;
        while (!bus16.done && lat < 20) begin tick(); lat++; end
        chk("b2b_sum1", 32'(bus16.sum), 32'h0010);
        chk("b2b_cout1", 32'(bus16.cout), 0);
        bus16.a = 16'h8000; bus16.b = 16'h8000; bus16.cin = 1'b0;
        q16.push_back(ref16(16'h8000, 16'h8000, 1'b0));
        gap = 0;
        do begin tick(); gap++; end while (!bus16.done && gap < 20);
        bus16.start = 1'b0;
        chk("b2b_gap", 32'(gap), NIB16 + 1);
        chk("b2b_sum2", 32'(bus16.sum), 32'h0000);
        chk("b2b_cout2", 32'(bus16.cout), 1);
        repeat (2) tick();

        ops = 0; it = 0; cnt = 0;
        while (ops < 1000 && it < 20000) begin
            it++;
            st = ($urandom_range(0, 3) != 0);
            bus16.start = st;
            bus16.a     = 16'($urandom);
            bus16.b     = 16'($urandom);
            bus16.cin   = 1'($urandom);
            chk("rnd_busy16", 32'(bus16.busy), 32'(cnt != 0));
            acc = st && (cnt == 0);
            if (acc) q16.push_back(ref16(bus16.a, bus16.b, bus16.cin));
            tick();
            ed = (cnt == 1);
            if (acc) begin cnt = NIB16; ops++; end
            else if (cnt > 0) cnt--;
            chk("rnd_done16", 32'(bus16.done), 32'(ed));
        end
        bus16.start = 1'b0;
        repeat (8) tick();

        ops = 0; it = 0; cnt = 0;
        while (ops < 1000 && it < 20000) begin
            it++;
            st = ($urandom_range(0, 3) != 0);
            bus8.start = st;
            bus8.a     = 8'($urandom);
            bus8.b     = 8'($urandom);
            bus8.cin   = 1'($urandom);
            chk("rnd_busy8", 32'(bus8.busy), 32'(cnt != 0));
            acc = st && (cnt == 0);
            if (acc) q8.push_back(ref8(bus8.a, bus8.b, bus8.cin));
            tick();
            ed = (cnt == 1);
            if (acc) begin cnt = NIB8; ops++; end
            else if (cnt > 0) cnt--;
            chk("rnd_done8", 32'(bus8.done), 32'(ed));
        end
        bus8.start = 1'b0;
        repeat (8) tick();

        chk("sb16_drained", 32'(q16.size()), 0);
        chk("sb8_drained", 32'(q8.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
